// File: rtl/scan_port_arbiter.sv
// scan_port_arbiter: LOAD/ANALYZE/ARM/RUN phase controller, BRAM port steering and scan-generator output arbiter.
// Optional RUN-phase watchdog enabled by defining SCAN_WATCHDOG_EN.
module scan_port_arbiter #(
  parameter int NUM_GEN         = 2,
  parameter int ADDR_W          = 14,
  parameter int DOUT_W          = 16,
  parameter int DAC_W           = 14,
  parameter int WR_DONE_CYCLES  = 10000,
  parameter int IDLE_CODE       = 8192,
  parameter int WATCHDOG_CYCLES = 2**24
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      recv_done,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [ADDR_W-1:0]         frame_addr,
  input  logic                      frame_rdy,
  input  logic [NUM_GEN-1:0]        gen_req,
  input  logic [NUM_GEN-1:0]        gen_done,
  input  logic [NUM_GEN*ADDR_W-1:0] gen_addr_a,
  input  logic [NUM_GEN*ADDR_W-1:0] gen_addr_b,
  input  logic [NUM_GEN*DAC_W-1:0]  gen_data_a,
  input  logic [NUM_GEN*DAC_W-1:0]  gen_data_b,
  input  logic [NUM_GEN-1:0]        gen_acq,
  input  logic [NUM_GEN-1:0]        gen_ccd,
  input  logic [DOUT_W-1:0]         ram_douta,
  input  logic [DOUT_W-1:0]         ram_doutb,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addra,
  output logic [ADDR_W-1:0]         ram_addrb,
  output logic [DOUT_W-1:0]         frame_data,
  output logic [DOUT_W-1:0]         gen_rd_a,
  output logic [DOUT_W-1:0]         gen_rd_b,
  output logic [NUM_GEN-1:0]        gen_grant,
  output logic                      gen_kill,
  output logic [DAC_W-1:0]          DataA,
  output logic [DAC_W-1:0]          DataB,
  output logic                      acq,
  output logic                      lvds_ccd_p,
  output logic                      lvds_ccd_n,
  output logic                      proc_finished,
  output logic [2:0]                phase,
  output logic                      watchdog_err
);
  typedef enum logic [2:0] {IDLE, LOAD, ANALYZE, ARM, RUN, DONE} phase_t;
  localparam int CW = $clog2(WR_DONE_CYCLES + 1);
  localparam logic [DAC_W-1:0] IDLE_DAC = DAC_W'(IDLE_CODE);
  if (NUM_GEN < 1 || NUM_GEN > 8 || WR_DONE_CYCLES < 2 || WATCHDOG_CYCLES < 2) begin : g_param_check
    $error("scan_port_arbiter: parameter out of range");
  end
  phase_t             st;
  logic [CW-1:0]      quiet_cnt;
  logic [ADDR_W-1:0]  sel_addr_a, sel_addr_b;
  logic [DAC_W-1:0]   sel_data_a, sel_data_b;
  logic               sel_acq, sel_ccd;
  logic [NUM_GEN-1:0] req_oh;
  logic               wd_hit, abort, done_hit;
  assign phase = st;
  always_comb begin
    sel_addr_a = '0;
    sel_addr_b = '0;
    sel_data_a = '0;
    sel_data_b = '0;
    sel_acq    = 1'b0;
    sel_ccd    = 1'b0;
    for (int i = 0; i < NUM_GEN; i++)
      if (gen_grant[i]) begin
        sel_addr_a = gen_addr_a[i*ADDR_W +: ADDR_W];
        sel_addr_b = gen_addr_b[i*ADDR_W +: ADDR_W];
        sel_data_a = gen_data_a[i*DAC_W +: DAC_W];
        sel_data_b = gen_data_b[i*DAC_W +: DAC_W];
        sel_acq    = gen_acq[i];
        sel_ccd    = gen_ccd[i];
      end
  end
  // two's-complement trick isolates the lowest set request bit
  assign req_oh    = gen_req & (~gen_req + NUM_GEN'(1));
  assign done_hit  = |(gen_done & gen_grant);
  assign abort     = (recv_done && st inside {ANALYZE, ARM, RUN, DONE}) || wd_hit;
  assign ram_we    = st == IDLE || st == LOAD;
  assign ram_addra = ram_we ? wr_addr : (st == RUN ? sel_addr_a : frame_addr);
  assign ram_addrb = st == RUN ? sel_addr_b : '0;
`ifdef SCAN_WATCHDOG_EN
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
  logic [WW-1:0] wd_cnt;
  assign wd_hit = st == RUN && wd_cnt == WW'(WATCHDOG_CYCLES - 1);
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wd_cnt       <= '0;
      watchdog_err <= 1'b0;
    end else begin
      wd_cnt       <= st == RUN ? wd_cnt + 1'b1 : '0;
      watchdog_err <= recv_done ? 1'b0 : (wd_hit ? 1'b1 : watchdog_err);
    end
  end
`else
  assign wd_hit       = 1'b0;
  assign watchdog_err = 1'b0;
`endif
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      st            <= IDLE;
      quiet_cnt     <= '0;
      gen_grant     <= '0;
      gen_kill      <= 1'b0;
      proc_finished <= 1'b0;
      frame_data    <= '0;
      gen_rd_a      <= '0;
      gen_rd_b      <= '0;
      DataA         <= IDLE_DAC;
      DataB         <= IDLE_DAC;
      acq           <= 1'b0;
      lvds_ccd_p    <= 1'b0;
      lvds_ccd_n    <= 1'b1;
    end else begin
      gen_kill      <= 1'b0;
      proc_finished <= 1'b0;
      DataA         <= IDLE_DAC;
      DataB         <= IDLE_DAC;
      acq           <= 1'b0;
      lvds_ccd_p    <= 1'b0;
      lvds_ccd_n    <= 1'b1;
      if (abort) begin
        st        <= LOAD;
        quiet_cnt <= '0;
        gen_kill  <= 1'b1;
        gen_grant <= '0;
      end else begin
        case (st)
          IDLE: if (recv_done) begin
            st        <= LOAD;
            quiet_cnt <= '0;
          end
          LOAD: begin
            if (recv_done) quiet_cnt <= '0;
            else if (quiet_cnt == CW'(WR_DONE_CYCLES - 1)) st <= ANALYZE;
            else quiet_cnt <= quiet_cnt + 1'b1;
          end
          ANALYZE: begin
            frame_data <= ram_douta;
            if (frame_rdy) st <= ARM;
          end
          ARM: if (|gen_req) begin
            gen_grant <= req_oh;
            st        <= RUN;
          end
          RUN: begin
            gen_rd_a <= ram_douta;
            gen_rd_b <= ram_doutb;
            if (done_hit) begin
              st            <= DONE;
              proc_finished <= 1'b1;
              gen_grant     <= '0;
            end else begin
              DataA      <= sel_data_a;
              DataB      <= sel_data_b;
              acq        <= sel_acq;
              lvds_ccd_p <= sel_ccd;
              lvds_ccd_n <= ~sel_ccd;
            end
          end
          DONE:    st <= IDLE;
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule
